// File: rtl/sys_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : sys_bus_initiator
// Brief    : Single-outstanding sys_bus initiator. Each accepted command
//            produces one bus strobe, then waits for ack/err (bounded by a
//            timeout) and returns the result on a valid/ready response port.
//            Saturating counters track responder errors and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module sys_bus_initiator #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_tmo,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_wen,
  output logic          bus_ren,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  input  logic          bus_err,
  output logic          busy,
  output logic [CW-1:0] cnt_err,
  output logic [CW-1:0] cnt_tmo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0]   C_TMO_LD  = 16'(TMO);
  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_tmo_q, rsp_tmo_d;
  logic [CW-1:0] cnt_err_q, cnt_err_d;
  logic [CW-1:0] cnt_tmo_q, cnt_tmo_d;

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    tmo_d       = tmo_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    cnt_err_d   = cnt_err_q;
    cnt_tmo_d   = cnt_tmo_q;
    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wr_d    = cmd_wr;
          // Strobe is registered here so it is high exactly in the ISSUE cycle.
          wen_d   = cmd_wr;
          ren_d   = ~cmd_wr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Responder signals during ISSUE are deliberately not sampled.
        tmo_d   = C_TMO_LD;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus_ack || bus_err) begin
          rsp_rdata_d = wr_q ? '0 : bus_rdata;
          rsp_err_d   = bus_err;
          rsp_tmo_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          state_d     = RESP;
          if (bus_err && (cnt_err_q != C_CNT_MAX)) begin
            cnt_err_d = cnt_err_q + C_CNT_ONE;
          end
        end else if (tmo_q == 16'd1) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_vld_d   = 1'b1;
          state_d     = RESP;
          if (cnt_tmo_q != C_CNT_MAX) begin
            cnt_tmo_d = cnt_tmo_q + C_CNT_ONE;
          end
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      RESP: begin
        // Late responder activity here is ignored; response held until taken.
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      tmo_q       <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      cnt_err_q   <= '0;
      cnt_tmo_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      tmo_q       <= tmo_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      cnt_err_q   <= cnt_err_d;
      cnt_tmo_q   <= cnt_tmo_d;
    end
  end

  assign cmd_rdy   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wen   = wen_q;
  assign bus_ren   = ren_q;
  assign cnt_err   = cnt_err_q;
  assign cnt_tmo   = cnt_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_bus_initiator
// Brief    : Directed, table-driven bench for sys_bus_initiator (TMO=8, CW=2)
//            with hand-written sequences for stall, late-response and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_bus_initiator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tmo;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic        busy;
  logic [1:0]  cnt_err;
  logic [1:0]  cnt_tmo;

  int n_chk  = 0;
  int n_fail = 0;

  sys_bus_initiator #(.AW(32), .DW(32), .TMO(8), .CW(2)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .busy(busy), .cnt_err(cnt_err), .cnt_tmo(cnt_tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. Called one time unit after a rising edge with the
  // DUT idle; cycle numbers are relative to the accept cycle N.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int dly, input logic ack, input logic err,
                         input logic [31:0] bdata, input logic [31:0] e_rdata,
                         input logic e_err, input logic e_tmo, input int e_lat,
                         input logic rdy);
    int cyc;
    chk("cmd_rdy_idle", {31'd0, cmd_rdy}, 32'd1);
    cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; rsp_rdy = rdy;
    step();
    cmd_vld = 1'b0; cmd_wr = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
    chk("issue_wen", {31'd0, bus_wen}, {31'd0, wr});
    chk("issue_ren", {31'd0, bus_ren}, {31'd0, ~wr});
    chk("issue_addr", bus_addr, addr);
    chk("issue_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    if (wr) chk("issue_wdata", bus_wdata, wdata);
    cyc = 1;
    while (rsp_vld !== 1'b1 && cyc < 40) begin
      if ((ack || err) && cyc == 1 + dly) begin
        bus_ack = ack; bus_err = err; bus_rdata = bdata;
      end
      step();
      cyc++;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'hDEAD_BEEF;
      if (rsp_vld !== 1'b1) begin
        chk("wait_strobes", {30'd0, bus_wen, bus_ren}, 32'd0);
        chk("wait_addr", bus_addr, addr);
        chk("wait_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
      end
    end
    chk("rsp_latency", cyc, e_lat);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
    chk("rsp_tmo", {31'd0, rsp_tmo}, {31'd0, e_tmo});
    chk("resp_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    if (rdy) begin
      step();
      chk("back_idle_rdy", {31'd0, cmd_rdy}, 32'd1);
      chk("back_idle_vld", {31'd0, rsp_vld}, 32'd0);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic        ack;
    logic        err;
    logic [31:0] bdata;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_tmo;
    int          e_lat;
    logic [1:0]  e_cerr;
    logic [1:0]  e_ctmo;
  } vec_t;

  vec_t vt[9];

  initial begin
    // wr addr wdata dly ack err bdata | rdata err tmo lat cnt_err cnt_tmo
    vt[0] = '{1'b1, 32'h4002_0010, 32'h0000_1234, 1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 3,  2'd0, 2'd0};
    vt[1] = '{1'b0, 32'h4002_0004, 32'h0,         3, 1'b1, 1'b0, 32'h0000_0ABC, 32'h0000_0ABC, 1'b0, 1'b0, 5,  2'd0, 2'd0};
    vt[2] = '{1'b0, 32'h0000_0010, 32'h0,         1, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 3,  2'd1, 2'd0};
    vt[3] = '{1'b1, 32'h0000_0020, 32'hDEAD_0001, 2, 1'b0, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 1'b0, 4,  2'd2, 2'd0};
    vt[4] = '{1'b0, 32'h0000_0030, 32'h0,         0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 10, 2'd2, 2'd1};
    vt[5] = '{1'b0, 32'h0000_0034, 32'h0,         8, 1'b1, 1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 1'b0, 10, 2'd2, 2'd1};
    vt[6] = '{1'b1, 32'h0000_0040, 32'hCAFE_0002, 1, 1'b1, 1'b1, 32'h0000_0099, 32'h0,         1'b1, 1'b0, 3,  2'd3, 2'd1};
    vt[7] = '{1'b0, 32'h0000_0044, 32'h0,         1, 1'b0, 1'b1, 32'h0000_0042, 32'h0000_0042, 1'b1, 1'b0, 3,  2'd3, 2'd1};
    vt[8] = '{1'b0, 32'h0000_0048, 32'h0,         4, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6,  2'd3, 2'd1};

    // Reset state, checked while reset is still asserted (no clock edge needed).
    #3;
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_strobes", {30'd0, bus_wen, bus_ren}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_counters", {28'd0, cnt_err, cnt_tmo}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Table-driven transactions.
    for (int i = 0; i < 9; i++) begin
      run_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].dly, vt[i].ack, vt[i].err,
              vt[i].bdata, vt[i].e_rdata, vt[i].e_err, vt[i].e_tmo, vt[i].e_lat, 1'b1);
      chk("tbl_cnt_err", {30'd0, cnt_err}, {30'd0, vt[i].e_cerr});
      chk("tbl_cnt_tmo", {30'd0, cnt_tmo}, {30'd0, vt[i].e_ctmo});
    end

    // Reset asserted mid-WAIT: immediate return to idle, counters cleared.
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_0050; rsp_rdy = 1'b1;
    step();
    cmd_vld = 1'b0;
    step();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("arst_strobes", {30'd0, bus_wen, bus_ren}, 32'd0);
    chk("arst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("arst_counters", {28'd0, cnt_err, cnt_tmo}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    begin
      int seen = 0;
      for (int k = 0; k < 12; k++) begin
        if (rsp_vld === 1'b1 || busy === 1'b1) seen++;
        step();
      end
      chk("arst_no_response", seen, 0);
    end
    run_txn(1'b1, 32'h0000_0060, 32'h0000_ABCD, 2, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4, 1'b1);

    // Timeout, then a late ack+err while idle must be discarded.
    run_txn(1'b0, 32'h0000_0070, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 10, 1'b1);
    chk("tmo_cnt_tmo", {30'd0, cnt_tmo}, 32'd1);
    step();
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ack = 1'b0; bus_err = 1'b0;
    chk("late_cnt_err", {30'd0, cnt_err}, 32'd0);
    chk("late_cnt_tmo", {30'd0, cnt_tmo}, 32'd1);
    chk("late_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("late_rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_tmo}, {30'd0, 1'b1, 1'b1});
    chk("late_busy", {31'd0, busy}, 32'd0);

    // Response back-pressure for 10 cycles with a pending command and stray ack/err.
    run_txn(1'b0, 32'h4002_0008, 32'h0, 1, 1'b1, 1'b0, 32'h0000_5A5A, 32'h0000_5A5A, 1'b0, 1'b0, 3, 1'b0);
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_0080;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h2222_2222; end
      step();
      bus_ack = 1'b0; bus_err = 1'b0;
      chk("stall_vld", {31'd0, rsp_vld}, 32'd1);
      chk("stall_rdata", rsp_rdata, 32'h0000_5A5A);
      chk("stall_err_tmo", {30'd0, rsp_err, rsp_tmo}, 32'd0);
      chk("stall_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("stall_strobes", {30'd0, bus_wen, bus_ren}, 32'd0);
      chk("stall_addr", bus_addr, 32'h4002_0008);
    end
    cmd_vld = 1'b0;
    rsp_rdy = 1'b1;
    step();
    chk("release_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("release_vld", {31'd0, rsp_vld}, 32'd0);
    chk("release_cnt_err", {30'd0, cnt_err}, 32'd0);
    step();
    chk("release_no_strobe", {30'd0, bus_wen, bus_ren}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
